comparador_secuencial: RTL

Sequential MSB-first ("left to right") magnitude comparator controller. It loads two N-bit words and walks them from the most significant slice to the least significant slice, M bits per cycle, through a single slice-comparison cell. It latches the first difference as the final result and reports greater, equal or less with a start/busy/done handshake. It sits between the operand registers and any consumer of a comparison result, and replaces the wide combinational comparator where area or timing matters more than latency.

---
 rtl/comparador_pkg.sv | 22 ++
 rtl/celda_comparadora.sv | 14 +
 rtl/comparador_secuencial.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/comparador_pkg.sv
// Shared types for the sequential MSB-first comparator: FSM states,
// pending-result encoding and the slice counter width helper.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] RES_GT = 2'd0;
  localparam logic [1:0] RES_EQ = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  // A single-slice operand still needs a 1-bit counter.
  function automatic int idx_width(input int n, input int m);
    int k;
    k = n / m;
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/celda_comparadora.sv
// M-bit combinational slice cell: flags a > b and a < b for one slice.
module celda_comparadora #(
  parameter int M = 2
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         sgt,
  output logic         slt
);

  assign sgt = (a > b);
  assign slt = (a < b);

endmodule

// File: rtl/comparador_secuencial.sv
// MSB-first sequential magnitude comparator, M bits per cycle.
// Define COMPARADOR_EARLY_EXIT_EN to leave SCAN on the first differing slice.
module comparador_secuencial
  import comparador_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] word_a,
  input  logic [N-1:0] word_b,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int K  = N / M;
  localparam int IW = idx_width(N, M);

  state_t         state_q, state_d;
  logic [N-1:0]   sa_q, sa_d, sb_q, sb_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           decided_q, decided_d;
  logic [1:0]     res_q, res_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic           sgt, slt, slice_diff, finish;

  celda_comparadora #(.M(M)) u_celda (
    .a   (sa_q[N-1 -: M]),
    .b   (sb_q[N-1 -: M]),
    .sgt (sgt),
    .slt (slt)
  );

  assign slice_diff = sgt | slt;

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    res_d     = res_q;
    busy_d    = busy_q;
    done_d    = done_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d      = word_a;
          sb_d      = word_b;
          idx_d     = IW'(K - 1);
          decided_d = 1'b0;
          res_d     = RES_EQ;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        // Only the first differing slice decides; later slices are ignored.
        if (!decided_q && slice_diff) begin
          decided_d = 1'b1;
          res_d     = sgt ? RES_GT : RES_LT;
        end
        sa_d = sa_q << M;
        sb_d = sb_q << M;
        if (idx_q != '0) idx_d = idx_q - IW'(1);
        finish = (idx_q == '0);
`ifdef COMPARADOR_EARLY_EXIT_EN
        finish = finish || (!decided_q && slice_diff);
`endif
        // Outputs are loaded on the way into DONE so they are valid with done.
        if (finish) begin
          state_d = DONE;
          done_d  = 1'b1;
          gt_d    = decided_d && (res_d == RES_GT);
          lt_d    = decided_d && (res_d == RES_LT);
          eq_d    = !decided_d;
        end
      end

      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= RES_EQ;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule
